// File: rtl/sqrt_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_fifo_core
// Purpose  : Integer square-root engine between two synchronous FIFOs. Pops
//            a radicand, computes floor(sqrt(x)) one root bit per cycle with
//            a bit-pair restoring algorithm, and pushes the root downstream.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_fifo_core #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_empty,
    output logic                 in_pop,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 out_full,
    output logic                 out_push,
    output logic [WIDTH/2-1:0]   out_data,
    output logic                 busy
);

    localparam int RW  = WIDTH / 2;
    localparam int RRW = RW + 2;
    localparam int CW  = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        PUSH = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_x;
    logic [RW-1:0]    r_q;
    logic [RRW-1:0]   r_r;
    logic [CW-1:0]    r_count;
    logic [RW-1:0]    r_out_data;

    logic             w_pop;
    logic             w_push;
    logic [RRW-1:0]   w_r_shift;
    logic [RRW-1:0]   w_trial;
    logic             w_ge;
    logic [RRW-1:0]   w_r_next;
    logic [RW-1:0]    w_q_next;

    // One restoring iteration: bring down the next bit pair and try to
    // subtract (4q + 1). The remainder never exceeds 2q, so RW+2 bits hold
    // the shifted value without loss.
    assign w_r_shift = (r_r << 2) | RRW'(r_x[WIDTH-1 -: 2]);
    assign w_trial   = {r_q, 2'b01};
    assign w_ge      = (w_r_shift >= w_trial);
    assign w_r_next  = w_ge ? (w_r_shift - w_trial) : w_r_shift;
    assign w_q_next  = {r_q[RW-2:0], w_ge};

    // Strobes are forced low while reset is held, since the IDLE pop
    // condition would otherwise follow in_empty during reset.
    assign in_pop   = w_pop & ~rst;
    assign out_push = w_push & ~rst;
    assign out_data = r_out_data;
    assign busy     = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and FIFO handshake strobes.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!in_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = LOAD;
                end
            end
            LOAD: w_state_next = CALC;
            CALC: begin
                if (r_count == '0) begin
                    w_state_next = PUSH;
                end
            end
            PUSH: begin
                if (!out_full) begin
                    w_push       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: capture radicand, iterate, and latch the finished root.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x        <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_count    <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_x     <= in_data;
                    r_q     <= '0;
                    r_r     <= '0;
                    r_count <= CW'(RW - 1);
                end
                CALC: begin
                    r_x <= {r_x[WIDTH-3:0], 2'b00};
                    r_q <= w_q_next;
                    r_r <= w_r_next;
                    if (r_count == '0) begin
                        r_out_data <= w_q_next;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_fifo_core
// Purpose  : Directed, table-driven bench for sqrt_fifo_core with a simple
//            upstream FIFO model feeding it and a push counter downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_fifo_core;

    localparam int WIDTH = 16;
    localparam int RW    = 8;

    logic             clk;
    logic             rst;
    logic             in_empty;
    logic             in_pop;
    logic [WIDTH-1:0] in_data;
    logic             out_full;
    logic             out_push;
    logic [RW-1:0]    out_data;
    logic             busy;

    sqrt_fifo_core #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_empty (in_empty),
        .in_pop   (in_pop),
        .in_data  (in_data),
        .out_full (out_full),
        .out_push (out_push),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [RW-1:0]    root;
    } vec_t;

    vec_t             vecs[18];
    logic [WIDTH-1:0] up_q[$];
    int               nvec;
    int               nerr;
    int               cyc;
    int               last_pop;
    int               pop_cnt;
    int               push_cnt;
    int               busy_cnt;
    logic             s_pop;
    logic             s_push;
    logic             s_busy;
    logic [RW-1:0]    s_data;

    task automatic chk(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] x);
        up_q.push_back(x);
        in_empty = 1'b0;
    endtask

    // One clock: sample outputs mid-cycle, then apply the FIFO effects of
    // the sampled strobes just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_pop  = in_pop;
        s_push = out_push;
        s_busy = busy;
        s_data = out_data;
        cyc++;
        if (s_busy) busy_cnt++;
        if (s_pop && s_push) begin
            nerr++;
            $display("FAIL pop_and_push: both strobes high in cycle %0d", cyc);
        end
        if (s_pop && s_busy) begin
            nerr++;
            $display("FAIL pop_when_busy: pop outside IDLE in cycle %0d", cyc);
        end
        @(posedge clk);
        #1;
        if (s_pop) begin
            pop_cnt++;
            last_pop = cyc;
            if (up_q.size() > 0) in_data = up_q.pop_front();
        end
        if (s_push) push_cnt++;
        in_empty = (up_q.size() == 0);
    endtask

    task automatic wait_push(input int budget, output logic got,
                             output logic [RW-1:0] d, output int pc);
        got = 1'b0;
        d   = '0;
        pc  = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            if (s_push) begin
                got = 1'b1;
                d   = s_data;
                pc  = cyc;
            end
        end
    endtask

    task automatic wait_pop(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            seen = s_pop;
        end
        if (!seen) chk("pop_timeout", 0, 1);
    endtask

    task automatic one(input string name, input logic [WIDTH-1:0] x,
                       input int exp);
        logic          got;
        logic [RW-1:0] d;
        int            pc;
        load(x);
        wait_push(40, got, d, pc);
        if (!got) chk({name, "_timeout"}, -1, exp);
        else      chk(name, int'(d), exp);
    endtask

    function automatic int isqrt(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic             got;
        logic [RW-1:0]    d;
        int               pc;
        int               pushes0;
        int               prev_pc;
        logic [WIDTH-1:0] sv[8];

        nvec = 0; nerr = 0; cyc = 0; last_pop = 0;
        pop_cnt = 0; push_cnt = 0; busy_cnt = 0;
        rst = 1'b1; in_empty = 1'b1; in_data = '0; out_full = 1'b0;

        vecs[0]  = '{16'd0,     8'd0};
        vecs[1]  = '{16'd1,     8'd1};
        vecs[2]  = '{16'd2,     8'd1};
        vecs[3]  = '{16'd143,   8'd11};
        vecs[4]  = '{16'd65535, 8'd255};
        vecs[5]  = '{16'd3,     8'd1};
        vecs[6]  = '{16'd4,     8'd2};
        vecs[7]  = '{16'd255,   8'd15};
        vecs[8]  = '{16'd256,   8'd16};
        vecs[9]  = '{16'd1000,  8'd31};
        vecs[10] = '{16'd12345, 8'd111};
        vecs[11] = '{16'd64516, 8'd254};
        vecs[12] = '{16'd65024, 8'd254};
        vecs[13] = '{16'd65025, 8'd255};
        vecs[14] = '{16'd65534, 8'd255};
        vecs[15] = '{16'd16383, 8'd127};
        vecs[16] = '{16'd16384, 8'd128};
        vecs[17] = '{16'd10000, 8'd100};

        // Reset state with a radicand already waiting upstream.
        load(16'd144);
        cycle();
        cycle();
        chk("rst_in_pop", int'(s_pop), 0);
        chk("rst_out_push", int'(s_push), 0);
        chk("rst_busy", int'(s_busy), 0);
        chk("rst_out_data", int'(s_data), 0);
        rst = 1'b0;

        // Single value: latency, result and busy window.
        busy_cnt = 0;
        pop_cnt  = 0;
        wait_push(40, got, d, pc);
        chk("lat_got_push", int'(got), 1);
        chk("lat_data_144", int'(d), 12);
        chk("lat_pop_to_push", pc - last_pop, 10);
        chk("lat_busy_cycles", busy_cnt, 10);
        chk("lat_pop_count", pop_cnt, 1);
        cycle();
        chk("lat_idle_after", int'(s_busy), 0);

        // Table of radicands, one at a time.
        pushes0 = push_cnt;
        for (int i = 0; i < 18; i++) begin
            one($sformatf("vec%0d_x%0d", i, vecs[i].x), vecs[i].x,
                int'(vecs[i].root));
        end
        chk("vec_push_count", push_cnt - pushes0, 18);

        // Back-pressure: hold PUSH for five cycles with more data waiting.
        out_full = 1'b1;
        load(16'd10000);
        load(16'd4);
        wait_pop(20);
        for (int i = 0; i < 9; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_no_push", int'(s_push), 0);
            chk("bp_no_pop", int'(s_pop), 0);
            chk("bp_busy", int'(s_busy), 1);
            chk("bp_data_hold", int'(s_data), 100);
        end
        out_full = 1'b0;
        cycle();
        chk("bp_push", int'(s_push), 1);
        chk("bp_push_data", int'(s_data), 100);
        wait_push(40, got, d, pc);
        chk("bp_next_data", got ? int'(d) : -1, 2);

        // Empty upstream: nothing happens for 20 cycles.
        cycle();
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_pop || s_push || s_busy) got = 1'b1;
        end
        chk("empty_quiet", int'(got), 0);
        one("empty_then_49", 16'd49, 7);

        // Reset in the middle of CALC discards the in-flight radicand.
        load(16'd900);
        wait_pop(20);
        for (int i = 0; i < 4; i++) cycle();
        pushes0 = push_cnt;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_push", int'(out_push), 0);
        chk("mid_rst_data", int'(out_data), 0);
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) cycle();
        chk("mid_rst_no_push", push_cnt - pushes0, 0);
        one("after_rst_81", 16'd81, 9);

        // Streaming: eight queued values, results spaced RW+3 cycles.
        for (int i = 0; i < 8; i++) begin
            sv[i] = WIDTH'($urandom_range(0, 65535));
            load(sv[i]);
        end
        pushes0 = push_cnt;
        prev_pc = 0;
        for (int i = 0; i < 8; i++) begin
            wait_push(40, got, d, pc);
            chk($sformatf("stream%0d_x%0d", i, sv[i]),
                got ? int'(d) : -1, isqrt(int'(sv[i])));
            if (i > 0) chk($sformatf("stream%0d_spacing", i), pc - prev_pc, 11);
            prev_pc = pc;
        end
        chk("stream_push_count", push_cnt - pushes0, 8);
        cycle();
        chk("stream_up_empty", int'(in_empty), 1);
        chk("stream_idle", int'(s_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
